// File: rtl/fip_div_seq.sv
// Signed QI.F divider, one quotient bit per clock: WIDTH+FRA_BITS+1 clocks accept-to-result (1 on y==0).
// Single operand in flight; o_ready only in IDLE, result held in DONE until i_ready.
module fip_div_seq #(
    parameter int WIDTH    = 32,
    parameter int FRA_BITS = 16,
    parameter int SAT      = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_z,
    output logic             o_ovf,
    output logic             o_dbz
);

    localparam int N  = WIDTH + FRA_BITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST  = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic             sign;
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] rem;
    logic [N-1:0]     dq;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] abs_x;
    logic [WIDTH-1:0] abs_y;
    logic             y_zero;
    logic [WIDTH:0]   rem_sh;
    logic             take;
    logic [WIDTH:0]   rem_nx;
    logic [N-1:0]     q_nx;
    logic [WIDTH-1:0] q_lo;
    logic [WIDTH-1:0] z_wrap;
    logic             ovf_nx;
    logic [WIDTH-1:0] z_nx;

    assign o_ready = (state == IDLE);

    // Magnitudes are taken unsigned, so |MIN| = 2^(WIDTH-1) is representable.
    assign abs_x  = i_x[WIDTH-1] ? -i_x : i_x;
    assign abs_y  = i_y[WIDTH-1] ? -i_y : i_y;
    assign y_zero = (i_y == '0);

    // dq starts as the dividend and fills with quotient bits from the LSB as it shifts out.
    assign rem_sh = {rem, dq[N-1]};
    assign take   = (rem_sh >= {1'b0, div_mag});
    assign rem_nx = take ? (rem_sh - {1'b0, div_mag}) : rem_sh;
    assign q_nx   = {dq[N-2:0], take};

    assign q_lo   = q_nx[WIDTH-1:0];
    assign z_wrap = sign ? -q_lo : q_lo;
    assign ovf_nx = sign ? (q_nx > N'(MIN_V)) : (q_nx > N'(MAX_V));
    assign z_nx   = (ovf_nx && (SAT != 0)) ? (sign ? MIN_V : MAX_V) : z_wrap;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_z     <= '0;
            o_ovf   <= 1'b0;
            o_dbz   <= 1'b0;
            cnt     <= '0;
            sign    <= 1'b0;
            div_mag <= '0;
            rem     <= '0;
            dq      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        sign    <= i_x[WIDTH-1] ^ i_y[WIDTH-1];
                        div_mag <= abs_y;
                        rem     <= '0;
                        dq      <= N'(abs_x) << FRA_BITS;
                        cnt     <= '0;
                        if (y_zero) begin
                            state   <= DONE;
                            o_valid <= 1'b1;
                            o_dbz   <= 1'b1;
                            o_ovf   <= 1'b1;
                            o_z     <= i_x[WIDTH-1] ? MIN_V : MAX_V;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nx[WIDTH-1:0];
                    dq  <= q_nx;
                    if (cnt == LAST) begin
                        // Last quotient bit lands this edge; the result is formed from it directly.
                        state   <= DONE;
                        cnt     <= '0;
                        o_valid <= 1'b1;
                        o_z     <= z_nx;
                        o_ovf   <= ovf_nx;
                        o_dbz   <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_z     <= '0;
                        o_ovf   <= 1'b0;
                        o_dbz   <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fip_div_seq.sv
// Bench for fip_div_seq: saturating and wrapping instances driven in lockstep, checked against an arithmetic model.
module tb_fip_div_seq;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [31:0] i_x = '0;
    logic [31:0] i_y = '0;

    logic        o_ready_a, o_valid_a, o_ovf_a, o_dbz_a;
    logic [31:0] o_z_a;
    logic        o_ready_b, o_valid_b, o_ovf_b, o_dbz_b;
    logic [31:0] o_z_b;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_za = '0;
    logic [31:0] exp_zb = '0;
    logic        exp_ovf = 1'b0;
    logic        exp_dbz = 1'b0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] za;
        logic [31:0] zb;
        logic        ovf;
        logic        dbz;
    } vec_t;

    vec_t dir [10];

    fip_div_seq #(.WIDTH(32), .FRA_BITS(16), .SAT(1)) dut_sat (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready_a),
        .i_x(i_x), .i_y(i_y), .o_valid(o_valid_a), .i_ready(i_ready),
        .o_z(o_z_a), .o_ovf(o_ovf_a), .o_dbz(o_dbz_a)
    );

    fip_div_seq #(.WIDTH(32), .FRA_BITS(16), .SAT(0)) dut_wrap (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready_b),
        .i_x(i_x), .i_y(i_y), .o_valid(o_valid_b), .i_ready(i_ready),
        .o_z(o_z_b), .o_ovf(o_ovf_b), .o_dbz(o_dbz_b)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division of magnitudes in Q16, then range rules.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input bit sat,
                                  output logic [31:0] z, output logic ovf, output logic dbz);
        longint sx, sy, ax, ay, q, r, lim;
        bit     neg;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ax  = (sx < 0) ? -sx : sx;
        ay  = (sy < 0) ? -sy : sy;
        neg = (sx < 0) != (sy < 0);
        if (ay == 0) begin
            dbz = 1'b1;
            ovf = 1'b1;
            z   = (sx < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            dbz = 1'b0;
            q   = (ax * 65536) / ay;
            lim = neg ? 64'sd2147483648 : 64'sd2147483647;
            ovf = (q > lim);
            r   = neg ? -q : q;
            if (ovf && sat) z = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else            z = 32'(r);
        end
    endfunction

    // Every cycle a result is presented, both instances must match the model.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                if (o_valid_a) begin
                    check("z_sat", o_z_a, exp_za);
                    check("ovf_sat", o_ovf_a, exp_ovf);
                    check("dbz_sat", o_dbz_a, exp_dbz);
                    check("ready_in_done", o_ready_a, 0);
                end
                if (o_valid_b) begin
                    check("z_wrap", o_z_b, exp_zb);
                    check("ovf_wrap", o_ovf_b, exp_ovf);
                    check("dbz_wrap", o_dbz_b, exp_dbz);
                end
            end
        end
    end

    task automatic run_div(input logic [31:0] x, input logic [31:0] y, input int hold,
                           input bit has_lit, input vec_t lit);
        logic [31:0] za, zb;
        logic        ov, dz;
        int          lat;
        model(x, y, 1'b1, za, ov, dz);
        model(x, y, 1'b0, zb, ov, dz);
        exp_za  = za;
        exp_zb  = zb;
        exp_ovf = ov;
        exp_dbz = dz;
        i_valid = 1'b1;
        i_x     = x;
        i_y     = y;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_x     = $urandom;
        i_y     = $urandom;
        lat = 1;
        while (!o_valid_a && lat < 60) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), dz ? 64'd1 : 64'd49);
        check("valid_pair", o_valid_b, o_valid_a);
        if (has_lit) begin
            check("lit_z_sat", o_z_a, lit.za);
            check("lit_z_wrap", o_z_b, lit.zb);
            check("lit_ovf", o_ovf_a, lit.ovf);
            check("lit_dbz", o_dbz_a, lit.dbz);
        end
        // Inputs wiggle while the result waits; nothing may change.
        repeat (hold) begin
            i_valid = 1'($urandom);
            i_x     = $urandom;
            i_y     = $urandom;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check("after_hs_valid", o_valid_a, 0);
        check("after_hs_ready", o_ready_a, 1);
    endtask

    initial begin
        vec_t none;
        none = '{x: 32'h0, y: 32'h0, za: 32'h0, zb: 32'h0, ovf: 1'b0, dbz: 1'b0};
        dir[0] = '{x: 32'h0002_0000, y: 32'h0002_0000, za: 32'h0001_0000, zb: 32'h0001_0000, ovf: 1'b0, dbz: 1'b0};
        dir[1] = '{x: 32'h0000_0002, y: 32'h0000_0003, za: 32'h0000_AAAA, zb: 32'h0000_AAAA, ovf: 1'b0, dbz: 1'b0};
        dir[2] = '{x: 32'hFFFF_0000, y: 32'h0000_8000, za: 32'hFFFE_0000, zb: 32'hFFFE_0000, ovf: 1'b0, dbz: 1'b0};
        dir[3] = '{x: 32'hFFFF_FFFF, y: 32'h0002_0000, za: 32'h0000_0000, zb: 32'h0000_0000, ovf: 1'b0, dbz: 1'b0};
        dir[4] = '{x: 32'h7FFF_FFFF, y: 32'h0000_4000, za: 32'h7FFF_FFFF, zb: 32'hFFFF_FFFC, ovf: 1'b1, dbz: 1'b0};
        dir[5] = '{x: 32'h8000_0000, y: 32'h0000_4000, za: 32'h8000_0000, zb: 32'h0000_0000, ovf: 1'b1, dbz: 1'b0};
        dir[6] = '{x: 32'h0005_0000, y: 32'h0000_0000, za: 32'h7FFF_FFFF, zb: 32'h7FFF_FFFF, ovf: 1'b1, dbz: 1'b1};
        dir[7] = '{x: 32'hFFFB_0000, y: 32'h0000_0000, za: 32'h8000_0000, zb: 32'h8000_0000, ovf: 1'b1, dbz: 1'b1};
        dir[8] = '{x: 32'h8000_0000, y: 32'hFFFF_0000, za: 32'h7FFF_FFFF, zb: 32'h8000_0000, ovf: 1'b1, dbz: 1'b0};
        dir[9] = '{x: 32'h8000_0000, y: 32'h0001_0000, za: 32'h8000_0000, zb: 32'h8000_0000, ovf: 1'b0, dbz: 1'b0};

        #12;
        check("rst_valid", o_valid_a, 0);
        check("rst_ready", o_ready_a, 1);
        check("rst_z", o_z_a, 0);
        check("rst_flags", {o_ovf_a, o_dbz_a}, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < 10; i++)
            run_div(dir[i].x, dir[i].y, (i == 2) ? 10 : 1, 1'b1, dir[i]);

        // Reset in the middle of a calculation discards it.
        i_valid = 1'b1;
        i_x     = 32'h0002_0000;
        i_y     = 32'h0001_0000;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (20) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        check("midrst_valid", o_valid_a, 0);
        check("midrst_ready", o_ready_a, 1);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        check("postrst_valid", o_valid_a, 0);
        none.x  = 32'h0003_0000;
        none.y  = 32'h0001_0000;
        none.za = 32'h0003_0000;
        none.zb = 32'h0003_0000;
        run_div(32'h0003_0000, 32'h0001_0000, 0, 1'b1, none);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] rx, ry;
            rx = $urandom;
            if ($urandom_range(0, 2) == 0) rx = 32'($signed(rx) >>> $urandom_range(8, 31));
            ry = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) ry = '0;
            if ($urandom_range(0, 1) == 1) ry = -ry;
            run_div(rx, ry, $urandom_range(0, 3), 1'b0, none);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
